instruction_decoder: RTL

Decodes the 8-bit instruction word returned by program memory into control for the datapath and the program sequencer. It drives `jmp`, `jmp_nz`, `jmp_addr` and `dont_jmp` into the sequencer, and owns the zero flag. It also generates the sequencer's `sync_reset` from the system asynchronous reset. It sits between program memory and the datapath/sequencer, so the processor core closes the fetch–decode loop.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/instruction_decoder_if.sv | 35 +++
 rtl/sync_reset_gen.sv | 54 +++++
 rtl/instruction_decoder.sv | 77 +++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction decoder: opcode prefixes, the
// immediate source select code and the reset sequencing state encoding.
package cpu_pkg;

    // Opcode prefixes, matched against the top bits of pm_data
    localparam logic       OP_LOAD = 1'b0;
    localparam logic [1:0] OP_MOVE = 2'b10;
    localparam logic [2:0] OP_ALU  = 3'b110;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_JNZ  = 4'b1111;

    localparam logic [3:0] SRC_IMM = 4'd8;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } rst_state_e;

endpackage

// File: rtl/instruction_decoder_if.sv
// Bundle between program memory / ALU, the decoder and the sequencer/datapath.
interface instruction_decoder_if;
    import cpu_pkg::*;

    // No handshake: pm_data and alu_zero are valid every cycle and every
    // output is either combinational from them or a registered state bit.
    logic [7:0] pm_data;
    logic       alu_zero;
    logic       sync_reset;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic [7:0] reg_en;
    logic [3:0] source_sel;
    logic [3:0] imm;
    logic       alu_en;
    logic [2:0] alu_func;
    logic       alu_sel;
    logic [7:0] ir;
    rst_state_e rst_state;

    modport master (
        output pm_data, alu_zero,
        input  sync_reset, jmp, jmp_nz, jmp_addr, dont_jmp, reg_en,
               source_sel, imm, alu_en, alu_func, alu_sel, ir, rst_state
    );

    modport slave (
        input  pm_data, alu_zero,
        output sync_reset, jmp, jmp_nz, jmp_addr, dont_jmp, reg_en,
               source_sel, imm, alu_en, alu_func, alu_sel, ir, rst_state
    );

endinterface

// File: rtl/sync_reset_gen.sv
// Reset sequencer: holds sync_reset for RST_HOLD clocks after the async
// reset releases, then enables decode via run.
module sync_reset_gen
    import cpu_pkg::*;
#(
    parameter int RST_HOLD = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       sync_reset,
    output logic       run,
    output rst_state_e state
);

    localparam int CW = 16;

    rst_state_e    state_next;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    // Counts edges spent in HOLD; HOLD is entered on the first released edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ST_HOLD) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RST:  state_next = (RST_HOLD <= 1) ? ST_RUN : ST_HOLD;
            ST_HOLD: if (cnt == CW'(RST_HOLD - 2)) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_RST;
        endcase
    end

    always_comb begin
        sync_reset = (state != ST_RUN);
        run        = (state == ST_RUN);
    end

endmodule

// File: rtl/instruction_decoder.sv
// Combinational instruction decode plus the zero flag and debug copy of the
// last executed instruction; all decode is gated off until the core runs.
module instruction_decoder
    import cpu_pkg::*;
#(
    parameter int RST_HOLD = 2
) (
    input logic                  clk,
    input logic                  reset,
    instruction_decoder_if.slave bus
);

    logic       run;
    logic       zero_flag;
    logic [7:0] ir_q;
    logic [7:0] pm;

    assign pm = bus.pm_data;

    sync_reset_gen #(
        .RST_HOLD (RST_HOLD)
    ) u_sync_reset_gen (
        .clk        (clk),
        .reset      (reset),
        .sync_reset (bus.sync_reset),
        .run        (run),
        .state      (bus.rst_state)
    );

    always_comb begin
        bus.jmp        = 1'b0;
        bus.jmp_nz     = 1'b0;
        bus.reg_en     = 8'h00;
        bus.source_sel = 4'h0;
        bus.alu_en     = 1'b0;
        bus.alu_func   = 3'h0;
        bus.alu_sel    = 1'b0;
        bus.jmp_addr   = pm[3:0];
        bus.imm        = pm[3:0];
        if (run) begin
            if (pm[7] == OP_LOAD) begin
                bus.reg_en[pm[6:4]] = 1'b1;
                bus.source_sel      = SRC_IMM;
            end else if (pm[7:6] == OP_MOVE) begin
                // A move onto itself is a no-op: no register is loaded
                if (pm[5:3] != pm[2:0]) begin
                    bus.reg_en[pm[5:3]] = 1'b1;
                end
                bus.source_sel = {1'b0, pm[2:0]};
            end else if (pm[7:5] == OP_ALU) begin
                bus.alu_en   = 1'b1;
                bus.alu_func = pm[2:0];
                bus.alu_sel  = pm[4];
            end else if (pm[7:4] == OP_JMP) begin
                bus.jmp = 1'b1;
            end else if (pm[7:4] == OP_JNZ) begin
                bus.jmp_nz = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_flag <= 1'b0;
            ir_q      <= 8'h00;
        end else if (run) begin
            ir_q <= pm;
            if (bus.alu_en) begin
                zero_flag <= bus.alu_zero;
            end
        end
    end

    assign bus.dont_jmp = zero_flag;
    assign bus.ir       = ir_q;

endmodule
